pc_fetch_unit: RTL

- Owns the architectural program counter. Consumes the jal/jalr/branch targets from the branch address generator, plus mtvec/mepc from the CSR file.
- Selects the next PC and issues fetch requests to instruction memory over a valid/ready handshake.
- Buffers redirects that arrive while a fetch is outstanding. Flags misaligned control-transfer targets and vectors them to mtvec.

---
 rtl/pc_fetch_unit_if.sv | 21 ++
 rtl/pc_fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/pc_fetch_unit_if.sv
// rtl/pc_fetch_unit_if.sv - instruction fetch request bus between fetch unit and imem
interface pc_fetch_unit_if;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_addr;
  logic        fetch_squash;

  modport master (
    output fetch_valid,
    output fetch_addr,
    output fetch_squash,
    input  fetch_ready
  );

  modport slave (
    input  fetch_valid,
    input  fetch_addr,
    input  fetch_squash,
    output fetch_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter owner, next-pc select and fetch request issue
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter int          XLEN      = 32
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [XLEN-1:0] jal,
  input  logic [XLEN-1:0] jalr,
  input  logic [XLEN-1:0] branch,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [2:0]      pc_source,
  input  logic            redirect_valid,
  pc_fetch_unit_if.master fetch,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            trap_misaligned,
  output logic [XLEN-1:0] bad_addr
);

  localparam logic [XLEN-1:0] WORD_MASK = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [XLEN-1:0] HALF_MASK = {{(XLEN-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    PEND  = 2'd2
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pend_target;
  logic [XLEN-1:0] raw_target;
  logic [XLEN-1:0] target;
  logic            is_cti;
  logic            redir;
  logic            misaligned;
  logic            accept;

  // Only sources 1..5 redirect; 0 and the reserved codes fall through to pc+4.
  always_comb begin
    raw_target = '0;
    is_cti     = 1'b0;
    redir      = 1'b0;
    case (pc_source)
      3'd1: begin raw_target = jalr & HALF_MASK; is_cti = 1'b1; redir = redirect_valid; end
      3'd2: begin raw_target = branch;           is_cti = 1'b1; redir = redirect_valid; end
      3'd3: begin raw_target = jal;              is_cti = 1'b1; redir = redirect_valid; end
      3'd4: begin raw_target = mtvec & WORD_MASK; redir = redirect_valid; end
      3'd5: begin raw_target = mepc & WORD_MASK;  redir = redirect_valid; end
      default: begin end
    endcase
    misaligned = is_cti && (raw_target[1:0] != 2'b00);
    target     = misaligned ? (mtvec & WORD_MASK) : raw_target;
  end

  assign accept             = fetch.fetch_valid && fetch.fetch_ready;
  assign fetch.fetch_valid  = (state != BOOT);
  assign fetch.fetch_addr   = pc;
  assign fetch.fetch_squash = accept && (redir || state == PEND);
  assign pc_plus4           = pc + XLEN'(4);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state           <= BOOT;
      pc              <= RESET_VEC;
      pend_target     <= '0;
      trap_misaligned <= 1'b0;
      bad_addr        <= '0;
    end else begin
      trap_misaligned <= redir && misaligned;
      if (redir && misaligned) begin
        bad_addr <= raw_target;
      end
      case (state)
        BOOT: begin
          if (redir) begin
            pc <= target;
          end
          state <= ISSUE;
        end
        ISSUE: begin
          if (redir) begin
            if (fetch.fetch_ready) begin
              pc <= target;
            end else begin
              pend_target <= target;
              state       <= PEND;
            end
          end else if (fetch.fetch_ready) begin
            pc <= pc_plus4;
          end
        end
        PEND: begin
          // The stalled address must stay put; a newer redirect only replaces the pending target.
          if (fetch.fetch_ready) begin
            pc    <= redir ? target : pend_target;
            state <= ISSUE;
          end else if (redir) begin
            pend_target <= target;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule
